video_stream_framer: RTL and testbench

- Parametrised AXI4-Stream video framer, the successor to the fixed-size pixel_generator output stage.
- Accepts pixels from the fractal compute engine on a valid/ready interface and buffers them in an internal FWFT FIFO.
- Packs channels into tdata, generates tuser (start of frame) and a mode-selectable tlast (end of line or end of frame), and counts frames.
- Sits between the compute core and the VDMA/video-out AXI-Stream port.

---
 rtl/video_stream_pkg.sv | 24 ++
 rtl/sync_fifo_fwft.sv | 58 +++++
 rtl/video_stream_framer.sv | 211 +++++++++++++++++++++
 tb/tb_video_stream_framer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_stream_pkg.sv
// Shared types and helpers for the video stream framer.
package video_stream_pkg;

  // Framer control states.
  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  // Latched tlast placement: end of frame only, or end of every line.
  localparam logic TLAST_FRAME = 1'b0;
  localparam logic TLAST_LINE  = 1'b1;

  // Bits needed to hold a counter value in the range 0..n-1 (at least 1).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Bits needed for a FIFO pointer over 'depth' entries, with one wrap bit.
  function automatic int ptr_w(input int depth);
    return cnt_w(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO. The head entry is visible on
// o_rd_data whenever o_empty is low; i_rd_en pops it. DEPTH must be a power
// of two so the pointers can wrap naturally.
module sync_fifo_fwft
  import video_stream_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = cnt_w(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic             w_wr;
  logic             w_rd;

  // Requests are qualified here so a caller can never overrun or underrun.
  assign w_wr = i_wr_en & ~o_full;
  assign w_rd = i_rd_en & ~o_empty;

  // Pointer update; the extra MSB distinguishes full from empty.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of the order the blocks are evaluated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Storage array write port.
  // NOTE: the array is deliberately not reset; emptiness comes from the
  // pointers, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/video_stream_framer.sv
// AXI4-Stream video framer: buffers pixels from the compute engine in a FWFT
// FIFO, packs them into tdata, and marks start of frame (tuser) and end of
// line or frame (tlast). Counts completed frames.
// Optional build macro TEST_PATTERN_EN adds a pattern_sel input that replaces
// the pixel stream with eight vertical colour bars.
module video_stream_framer
  import video_stream_pkg::*;
#(
  parameter int X_SIZE     = 640,
  parameter int Y_SIZE     = 480,
  parameter int PIX_W      = 8,
  parameter int CHANNELS   = 3,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                      out_stream_aclk,
  input  logic                      axi_resetn,
  input  logic                      enable,
  input  logic                      tlast_mode,
`ifdef TEST_PATTERN_EN
  input  logic                      pattern_sel,
`endif
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PIX_W*CHANNELS-1:0] in_data,
  output logic [DATA_W-1:0]         out_stream_tdata,
  output logic [DATA_W/8-1:0]       out_stream_tkeep,
  output logic                      out_stream_tvalid,
  input  logic                      out_stream_tready,
  output logic                      out_stream_tlast,
  output logic                      out_stream_tuser,
  output logic                      busy,
  output logic                      frame_done,
  output logic [15:0]               frame_count
);

  localparam int PXW = PIX_W * CHANNELS;
  localparam int XW  = cnt_w(X_SIZE);
  localparam int YW  = cnt_w(Y_SIZE);

  state_e          r_state;
  state_e          w_state_next;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic            r_mode;
  logic            r_frame_done;
  logic [15:0]     r_frame_count;
  logic            r_in_en;

  logic            w_fifo_full;
  logic            w_fifo_empty;
  logic            w_fifo_wr;
  logic            w_fifo_rd;
  logic [PXW-1:0]  w_fifo_data;

  logic            w_pat_on;
  logic [PXW-1:0]  w_pix;
  logic            w_tvalid;
  logic            w_hs;
  logic            w_x_last;
  logic            w_y_last;
  logic            w_frame_last;
  logic            w_frame_start;

  // ---------------------------------------------------------------------------
  // Input buffer
  // ---------------------------------------------------------------------------
  sync_fifo_fwft #(
    .WIDTH (PXW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (out_stream_aclk),
    .rst_n     (axi_resetn),
    .i_wr_en   (w_fifo_wr),
    .i_wr_data (in_data),
    .i_rd_en   (w_fifo_rd),
    .o_rd_data (w_fifo_data),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty)
  );

  // Hold in_ready low while reset is asserted and for the first edge after it.
  always_ff @(posedge out_stream_aclk or negedge axi_resetn) begin
    if (!axi_resetn) r_in_en <= 1'b0;
    else             r_in_en <= 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Beat bookkeeping
  // ---------------------------------------------------------------------------
  assign w_tvalid      = (r_state == STREAM) & (w_pat_on | ~w_fifo_empty);
  assign w_hs          = w_tvalid & out_stream_tready;
  assign w_x_last      = (r_x == XW'(X_SIZE - 1));
  assign w_y_last      = (r_y == YW'(Y_SIZE - 1));
  assign w_frame_last  = w_hs & w_x_last & w_y_last;
  // Frame-level settings are captured when leaving IDLE and at each frame end.
  assign w_frame_start = ((r_state == IDLE) & enable) | w_frame_last;

  assign in_ready  = r_in_en & ~w_fifo_full & ~w_pat_on;
  assign w_fifo_wr = in_valid & in_ready;
  assign w_fifo_rd = w_hs & ~w_pat_on;

`ifdef TEST_PATTERN_EN
  logic            r_pattern;
  logic [XW+2:0]   w_x8;
  logic [XW+2:0]   w_bar_full;
  logic [2:0]      w_bar;
  logic [PXW-1:0]  w_pattern;

  // Pattern selection is a per-frame setting, latched with tlast_mode.
  always_ff @(posedge out_stream_aclk or negedge axi_resetn) begin
    if (!axi_resetn)        r_pattern <= 1'b0;
    else if (w_frame_start) r_pattern <= pattern_sel;
  end

  assign w_pat_on   = r_pattern;
  assign w_x8       = {r_x, 3'b000};
  assign w_bar_full = w_x8 / (XW+3)'(X_SIZE);
  assign w_bar      = w_bar_full[2:0];

  // Colour bars: each channel is all ones or all zeros from one bar-index bit.
  always_comb begin
    w_pattern = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_pattern[c*PIX_W +: PIX_W] = {PIX_W{w_bar[c % 3]}};
    end
  end

  assign w_pix = w_pat_on ? w_pattern : w_fifo_data;
`else
  assign w_pat_on = 1'b0;
  assign w_pix    = w_fifo_data;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------

  // State register.
  always_ff @(posedge out_stream_aclk or negedge axi_resetn) begin
    if (!axi_resetn) r_state <= IDLE;
    else             r_state <= w_state_next;
  end

  // Next-state logic: a frame in flight always finishes before going idle.
  // NOTE: every signal driven in a combinational block gets a default first,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (enable) w_state_next = STREAM;
      STREAM:  if (w_frame_last && !enable) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Output logic: sideband is qualified by tvalid so idle outputs read zero.
  always_comb begin
    out_stream_tvalid = w_tvalid;
    out_stream_tdata  = '0;
    out_stream_tuser  = 1'b0;
    out_stream_tlast  = 1'b0;
    if (w_tvalid) begin
      out_stream_tdata[PXW-1:0] = w_pix;
      out_stream_tuser = (r_x == '0) && (r_y == '0);
      out_stream_tlast = w_x_last && ((r_mode == TLAST_LINE) || w_y_last);
    end
    busy        = (r_state != IDLE);
    frame_done  = r_frame_done;
    frame_count = r_frame_count;
  end

  assign out_stream_tkeep = '1;

  // ---------------------------------------------------------------------------
  // Counters
  // ---------------------------------------------------------------------------

  // tlast placement latched per frame.
  always_ff @(posedge out_stream_aclk or negedge axi_resetn) begin
    if (!axi_resetn)        r_mode <= TLAST_FRAME;
    else if (w_frame_start) r_mode <= tlast_mode;
  end

  // Pixel position advances only on an accepted beat.
  always_ff @(posedge out_stream_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_hs) begin
      if (w_x_last) begin
        r_x <= '0;
        r_y <= w_y_last ? '0 : r_y + YW'(1);
      end else begin
        r_x <= r_x + XW'(1);
      end
    end
  end

  // Frame completion pulse and wrapping frame counter.
  always_ff @(posedge out_stream_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_frame_done <= w_frame_last;
      if (w_frame_last) r_frame_count <= r_frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_video_stream_framer.sv
// Directed bench for video_stream_framer with a 4x2 frame and 16-deep FIFO.
module tb_video_stream_framer;

  localparam int X  = 4;
  localparam int Y  = 2;
  localparam int DW = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        tlast_mode = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_data = '0;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tvalid;
  logic        tready = 1'b0;
  logic        tlast;
  logic        tuser;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  video_stream_framer #(
    .X_SIZE(X), .Y_SIZE(Y), .PIX_W(8), .CHANNELS(3), .DATA_W(DW), .FIFO_DEPTH(16)
  ) dut (
    .out_stream_aclk   (clk),
    .axi_resetn        (rst_n),
    .enable            (enable),
    .tlast_mode        (tlast_mode),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .out_stream_tdata  (tdata),
    .out_stream_tkeep  (tkeep),
    .out_stream_tvalid (tvalid),
    .out_stream_tready (tready),
    .out_stream_tlast  (tlast),
    .out_stream_tuser  (tuser),
    .busy              (busy),
    .frame_done        (frame_done),
    .frame_count       (frame_count)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] q_data[$];
  logic        q_last[$];
  logic        q_user[$];
  int          fd_seen;

  logic        s_valid, s_ready, s_last, s_user, s_busy;
  logic [31:0] s_data;
  logic [15:0] s_fc;

  // One clock: sample at negedge, record beats, advance source data on writes.
  task automatic step();
    logic wr;
    @(negedge clk);
    s_valid = tvalid; s_ready = tready; s_data = tdata;
    s_last = tlast; s_user = tuser; s_busy = busy; s_fc = frame_count;
    wr = in_valid && in_ready;
    if (tvalid && tready) begin
      q_data.push_back(tdata);
      q_last.push_back(tlast);
      q_user.push_back(tuser);
    end
    if (frame_done) fd_seen++;
    @(posedge clk);
    #1;
    if (wr) in_data = in_data + 24'd1;
  endtask

  task automatic wait_beats(input int n, input int budget, output bit ok);
    int c = 0;
    while (q_data.size() < n && c < budget) begin
      step();
      c++;
    end
    ok = (q_data.size() >= n);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; enable = 1'b0; in_valid = 1'b0; tready = 1'b0;
    tlast_mode = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    q_data.delete(); q_last.delete(); q_user.delete();
    fd_seen = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({tvalid, tlast, tuser, busy, frame_done, in_ready} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=000000", {tvalid, tlast, tuser, busy, frame_done, in_ready});
    end
    total++;
    if (tdata !== 32'h0 || frame_count !== 16'h0) begin
      bad++;
      $display("FAIL reset_data tdata=%0h fc=%0h want 0/0", tdata, frame_count);
    end
    total++;
    if (tkeep !== 4'hF) begin
      bad++;
      $display("FAIL reset_tkeep got=%0h want=f", tkeep);
    end
  endtask

  // Common single-frame run with enable dropped right after start.
  task automatic one_frame(input logic mode, input string tag);
    bit ok;
    apply_reset();
    tlast_mode = mode; enable = 1'b1; in_valid = 1'b1; tready = 1'b1;
    step();
    enable = 1'b0;
    wait_beats(8, 40, ok);
    in_valid = 1'b0;
    repeat (4) step();
    total++;
    if (!ok || q_data.size() != 8) begin
      bad++;
      $display("FAIL %s_beats got=%0d want=8", tag, q_data.size());
    end
    for (int i = 0; i < 8 && i < q_data.size(); i++) begin
      total++;
      if (q_data[i] !== 32'(i) || q_user[i] !== (i == 0) ||
          q_last[i] !== (mode ? (i % X == X - 1) : (i == 7))) begin
        bad++;
        $display("FAIL %s_beat%0d got d=%0h u=%b l=%b", tag, i, q_data[i], q_user[i], q_last[i]);
      end
    end
    total++;
    if (fd_seen != 1 || s_fc !== 16'd1 || s_busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_end fd=%0d fc=%0d busy=%b want 1/1/0", tag, fd_seen, s_fc, s_busy);
    end
  endtask

  task automatic test_frame_mode();
    one_frame(1'b0, "frame");
  endtask

  task automatic test_line_mode();
    one_frame(1'b1, "line");
  endtask

  task automatic test_backpressure();
    logic        p_valid, p_ready, p_last, p_user;
    logic [31:0] p_data;
    int          cyc = 0;
    apply_reset();
    enable = 1'b1; in_valid = 1'b1;
    p_valid = 1'b0; p_ready = 1'b1; p_last = 1'b0; p_user = 1'b0; p_data = '0;
    while (q_data.size() < 8 && cyc < 80) begin
      tready = (cyc % 2 == 0);
      step();
      if (p_valid && !p_ready) begin
        total++;
        if (!s_valid || s_data !== p_data || s_last !== p_last || s_user !== p_user) begin
          bad++;
          $display("FAIL hold_stable got v=%b d=%0h l=%b u=%b want v=1 d=%0h l=%b u=%b",
                   s_valid, s_data, s_last, s_user, p_data, p_last, p_user);
        end
      end
      p_valid = s_valid; p_ready = s_ready; p_data = s_data; p_last = s_last; p_user = s_user;
      cyc++;
    end
    total++;
    if (q_data.size() < 8) begin
      bad++;
      $display("FAIL bp_beats got=%0d want=8", q_data.size());
    end
    for (int i = 0; i < 8 && i < q_data.size(); i++) begin
      total++;
      if (q_data[i] !== 32'(i)) begin
        bad++;
        $display("FAIL bp_data%0d got=%0h want=%0h", i, q_data[i], i);
      end
    end
  endtask

  task automatic test_underflow();
    bit   ok;
    logic v[5];
    apply_reset();
    enable = 1'b1; in_valid = 1'b1; tready = 1'b1;
    wait_beats(2, 20, ok);
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      v[k] = s_valid;
    end
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      total++;
      if (v[k] !== (k == 0)) begin
        bad++;
        $display("FAIL gap_tvalid%0d got=%b want=%b", k, v[k], (k == 0));
      end
    end
    wait_beats(8, 40, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL uf_beats got=%0d want=8", q_data.size());
    end
    for (int i = 0; i < 8 && i < q_data.size(); i++) begin
      total++;
      if (q_data[i] !== 32'(i) || q_user[i] !== (i == 0) || q_last[i] !== (i == 7)) begin
        bad++;
        $display("FAIL uf_beat%0d got d=%0h u=%b l=%b", i, q_data[i], q_user[i], q_last[i]);
      end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    apply_reset();
    enable = 1'b1; in_valid = 1'b1; tready = 1'b0;
    repeat (24) step();
    total++;
    if (in_data !== 24'd16 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL ov_fill writes=%0d ready=%b want 16/0", in_data, in_ready);
    end
    total++;
    if (!s_valid || s_data !== 32'h0) begin
      bad++;
      $display("FAIL ov_head got v=%b d=%0h want v=1 d=0", s_valid, s_data);
    end
    in_valid = 1'b0; tready = 1'b1;
    wait_beats(16, 60, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL ov_beats got=%0d want=16", q_data.size());
    end
    for (int i = 0; i < 16 && i < q_data.size(); i++) begin
      total++;
      if (q_data[i] !== 32'(i) || q_user[i] !== (i % 8 == 0)) begin
        bad++;
        $display("FAIL ov_beat%0d got d=%0h u=%b", i, q_data[i], q_user[i]);
      end
    end
  endtask

  task automatic test_enable_drop();
    bit ok;
    apply_reset();
    enable = 1'b1; in_valid = 1'b1; tready = 1'b1;
    wait_beats(12, 80, ok);
    enable = 1'b0;
    repeat (30) step();
    total++;
    if (q_data.size() != 16) begin
      bad++;
      $display("FAIL drop_beats got=%0d want=16", q_data.size());
    end
    total++;
    if (s_busy !== 1'b0 || s_valid !== 1'b0 || s_fc !== 16'd2 || fd_seen != 2) begin
      bad++;
      $display("FAIL drop_end busy=%b v=%b fc=%0d fd=%0d want 0/0/2/2", s_busy, s_valid, s_fc, fd_seen);
    end
    if (q_data.size() >= 16) begin
      total++;
      if (q_data[15] !== 32'd15 || q_last[15] !== 1'b1 || q_user[8] !== 1'b1) begin
        bad++;
        $display("FAIL drop_last got d=%0h l=%b u8=%b want f/1/1", q_data[15], q_last[15], q_user[8]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    apply_reset();
    enable = 1'b1; in_valid = 1'b1; tready = 1'b1;
    wait_beats(13, 80, ok);
    total++;
    if (!ok || s_fc !== 16'd1) begin
      bad++;
      $display("FAIL mid_pre beats=%0d fc=%0d want 13/1", q_data.size(), s_fc);
    end
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    total++;
    if ({tvalid, tlast, tuser, busy, in_ready} !== 5'b0 || tdata !== 32'h0 || frame_count !== 16'h0) begin
      bad++;
      $display("FAIL mid_rst ctrl=%b tdata=%0h fc=%0h want 0", {tvalid, tlast, tuser, busy, in_ready}, tdata, frame_count);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_data = 24'd100; in_valid = 1'b1;
    q_data.delete(); q_last.delete(); q_user.delete();
    wait_beats(1, 20, ok);
    total++;
    if (!ok || q_data[0] !== 32'd100 || q_user[0] !== 1'b1 || s_fc !== 16'd0) begin
      bad++;
      $display("FAIL mid_restart beats=%0d d=%0h u=%b fc=%0d want 1/64/1/0",
               q_data.size(), ok ? q_data[0] : 32'h0, ok ? q_user[0] : 1'b0, s_fc);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame_mode();
    test_line_mode();
    test_backpressure();
    test_underflow();
    test_overflow();
    test_enable_drop();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
